// File: rtl/audio_seq_pkg.sv
// Shared types for the step sequencer: pattern entry layout, FSM states, tempo floor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_seq_pkg;
    localparam int SEQ_GATE_BIT  = 15;
    localparam int DEF_MIN_TEMPO = 8;

    typedef struct packed {
        logic                    gate;
        logic [SEQ_GATE_BIT-1:0] freq;
    } seq_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_ADV,
        ST_CLR
    } seq_state_t;
endpackage

// File: rtl/step_timer.sv
// Step tick generator: clamps tempo_div, applies optional swing (NOTE_SEQ_SWING_EN), emits one-cycle tick.
// Latency: tick fires when the counter reaches period-1; period is sampled at each period start.
// Backpressure: none; counter holds at 0 while en is low.
module step_timer
    import audio_seq_pkg::*;
#(
    parameter int MIN_TEMPO = DEF_MIN_TEMPO
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        parity,
    input  logic [31:0] tempo_div,
    output logic        tick
);
    localparam logic [31:0] MIN_P = 32'(MIN_TEMPO);

    logic [31:0] cnt;
    logic [31:0] per_q;
    logic [31:0] per_base;
    logic [31:0] per_nxt;
    logic [32:0] per_sw;

    always_comb begin
        per_base = (tempo_div < MIN_P) ? MIN_P : tempo_div;
`ifdef NOTE_SEQ_SWING_EN
        // Even steps are shortened and odd steps lengthened by a quarter period.
        if (parity)
            per_sw = {1'b0, per_base} + {3'b0, per_base[31:2]};
        else
            per_sw = {1'b0, per_base} - {3'b0, per_base[31:2]};
`else
        per_sw = {1'b0, per_base};
`endif
        if (per_sw[32])
            per_nxt = '1;
        else if (per_sw[31:0] < MIN_P)
            per_nxt = MIN_P;
        else
            per_nxt = per_sw[31:0];
    end

`ifndef NOTE_SEQ_SWING_EN
    logic unused_parity;
    assign unused_parity = parity;
`endif

    assign tick = en && (cnt == per_q - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            per_q <= MIN_P;
        end else if (!en || tick) begin
            cnt   <= '0;
            per_q <= per_nxt;
        end else begin
            cnt   <= cnt + 32'd1;
        end
    end
endmodule

// File: rtl/note_sequencer.sv
// 16-step pattern sequencer; sole master of the single-port pattern RAM. Swing via NOTE_SEQ_SWING_EN.
// Latency: tick to trigger 3 cycles (4 when recording); clear sweep takes STEPS cycles.
// Backpressure: none; clear is dropped unless idle, run falling finishes the current step first.
module note_sequencer
    import audio_seq_pkg::*;
#(
    parameter int STEPS     = 16,
    parameter int ADDR_W    = 4,
    parameter int FREQ_W    = 32,
    parameter int MIN_TEMPO = DEF_MIN_TEMPO
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              run,
    input  logic [31:0]       tempo_div,
    input  logic              rec,
    input  logic [15:0]       rec_entry,
    input  logic              clear,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic [FREQ_W-1:0] freq,
    output logic              gate,
    output logic              trigger,
    output logic [ADDR_W-1:0] step,
    output logic              busy
);
    seq_state_t        state;
    logic              rec_q;
    logic [ADDR_W-1:0] clr_idx;
    logic              tick;
    logic              timer_en;
    seq_entry_t        cur;

    // The timer keeps counting through the RAM access so the step period never stretches.
    assign timer_en = (state != ST_IDLE) && (state != ST_CLR);
    assign cur      = (state == ST_WR) ? rec_entry : mem_rdata;
    assign busy     = (state == ST_CLR);

    step_timer #(.MIN_TEMPO(MIN_TEMPO)) u_timer (
        .clk       (sys_clk),
        .rst_n     (reset),
        .en        (timer_en),
        .parity    (step[0]),
        .tempo_div (tempo_div),
        .tick      (tick)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wren  = 1'b0;
        mem_wdata = '0;
        case (state)
            ST_RD:  mem_addr = step;
            ST_WR: begin
                mem_addr  = step;
                mem_wren  = 1'b1;
                mem_wdata = rec_entry;
            end
            ST_CLR: begin
                mem_addr = clr_idx;
                mem_wren = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            rec_q   <= 1'b0;
            clr_idx <= '0;
            step    <= '0;
            freq    <= '0;
            gate    <= 1'b0;
            trigger <= 1'b0;
        end else begin
            trigger <= 1'b0;
            case (state)
                ST_IDLE: begin
                    clr_idx <= '0;
                    if (run)
                        state <= ST_RD;
                    else if (clear)
                        state <= ST_CLR;
                end
                ST_WAIT: begin
                    if (tick) begin
                        if (run) begin
                            state <= ST_RD;
                        end else begin
                            state <= ST_IDLE;
                            gate  <= 1'b0;
                        end
                    end
                end
                ST_RD: begin
                    rec_q <= rec;
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    if (rec_q) begin
                        state <= ST_WR;
                    end else begin
                        // Outputs load on entry to ADV so they are visible during ADV itself.
                        freq    <= FREQ_W'(cur.freq);
                        gate    <= cur.gate;
                        trigger <= cur.gate;
                        state   <= ST_ADV;
                    end
                end
                ST_WR: begin
                    freq    <= FREQ_W'(cur.freq);
                    gate    <= cur.gate;
                    trigger <= cur.gate;
                    state   <= ST_ADV;
                end
                ST_ADV: begin
                    step <= (step == ADDR_W'(STEPS - 1)) ? '0 : step + 1'b1;
                    if (run) begin
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                        gate  <= 1'b0;
                    end
                end
                ST_CLR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == ADDR_W'(STEPS - 1)) begin
                        step  <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
